uxn_vram_layered: RTL and testbench
===================================

Name: uxn_vram_layered

Overview:
Parametrised multi-layer pixel VRAM for the Varvara screen device, the successor to the single-layer 2-bit VRAM. It holds LAYERS independent planes (background, foreground, ...) of PIXEL_W-bit pixels and returns a composited pixel on a pipelined read port. A built-in clear engine fills selected layers with a constant value, one address per cycle. It sits between the uxn screen-device write logic and the video scan-out reader, on one clock.

Parameters:
PIXEL_W, 2, bits per pixel per layer
ADDR_W, 17, address width; DEPTH = 2**ADDR_W pixels per layer
LAYERS, 2, number of layers (>=1); LAYER_W = max(1, clog2(LAYERS))

Ports:
clk  input  1  single clock for all logic
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  host write strobe
wr_layer  input  LAYER_W  target layer of host write
wr_addr  input  ADDR_W  host write address
wr_value  input  PIXEL_W  host write data
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
rd_value  output  PIXEL_W  composited pixel
rd_valid  output  1  rd_value valid this cycle
clr_start  input  1  start-clear pulse
clr_mask  input  LAYERS  layers to clear (bit i = layer i)
clr_value  input  PIXEL_W  fill value
clr_busy  output  1  clear engine active
clr_done  output  1  one-cycle pulse when clear finishes

Behaviour:
- Reset (async assert, sync release): rd_value=0, rd_valid=0, clr_busy=0, clr_done=0, FSM=IDLE, clear counter=0. RAM contents are not reset. Reset mid-clear aborts; already-cleared addresses stay cleared, the rest keep old data.
- Host write: on a clk edge with wr_en=1, ram[wr_layer][wr_addr] <= wr_value. wr_layer >= LAYERS: write dropped.
- Read: 2-cycle latency. Stage 1 registers all layers at rd_addr and registers rd_en. Stage 2 registers the composite into rd_value and sets rd_valid = delayed rd_en. rd_value holds its last value when rd_valid=0. Back-to-back reads every cycle are supported.
- Composite: the highest-index layer whose pixel != 0 wins. If all layers are 0, rd_value = layer 0 pixel (0).
- Same-address read/write in one cycle: read returns old data (read-before-write).
- Clear FSM, IDLE -> CLEAR:
  - In IDLE, clr_start=1 captures clr_mask and clr_value, sets counter=0, and sets clr_busy=1 on the next cycle.
  - In CLEAR, each cycle writes clr_value at address=counter into every masked layer, then counter++.
  - The write at counter = DEPTH-1 returns the FSM to IDLE. clr_busy drops and clr_done pulses high for one cycle on the following cycle.
  - Total duration: DEPTH busy cycles.
- clr_mask = 0: engine still runs DEPTH cycles and writes nothing. clr_done still pulses.
- clr_start while busy: ignored. Captured mask and value are unchanged.
- Host write during CLEAR:
  - Dropped if wr_layer is in the captured mask.
  - Accepted if wr_layer is not in the mask.
- Reads during CLEAR: allowed; they return current RAM contents.
- Counter is ADDR_W+1 bits; no wrap beyond DEPTH-1.

Test Plan:
(Bench uses ADDR_W=4, LAYERS=2, PIXEL_W=2.)
1. Reset with reset_n=0 mid-cycle -> all outputs 0 immediately (async), FSM IDLE. After release, rd_en with no prior writes -> rd_valid=1 two cycles later.
2. Write L0@5=1, L1@5=0, L0@6=2, L1@6=3. Read 5 -> rd_value=1 at +2 cycles. Read 6 -> 3. Read 7 (both layers 0) -> 0. Reads issued on consecutive cycles -> valid on consecutive cycles.
3. Same-cycle write L1@9=2 and read 9 (prior 0) -> rd_value=0. Re-read 9 -> 2.
4. clr_start with mask=2'b10, value=1 -> clr_busy high for exactly 16 cycles, then clr_done for 1 cycle. Reads of all addresses -> 1 (layer 1 wins). Layer 0 data unchanged (verified after writing L1=0 everywhere).
5. During a clear with mask=2'b01:
   - wr_en to L0@3 -> dropped.
   - wr_en to L1@3=2 -> accepted.
   - Second clr_start -> ignored; busy length stays 16.
6. reset_n asserted after 8 clear cycles -> clr_busy=0, no clr_done. Addresses 0-7 hold the cleared value; 8-15 hold prior data.
7. wr_layer=1 with LAYERS=1 build -> no write. clr_mask=0 -> 16 busy cycles, RAM unchanged, clr_done pulses.

Source files
------------

// File: rtl/uxn_vram_layered.sv
// Multi-layer pixel VRAM for the Varvara screen device.
// Holds LAYERS planes of PIXEL_W-bit pixels. Reads return the highest
// non-zero layer's pixel after two cycles. A clear engine fills the
// selected layers with a constant value, one address per cycle.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   wr_en/wr_layer/wr_addr/wr_value   host pixel write
//   rd_en/rd_addr                read request
//   rd_value/rd_valid            composited pixel, 2-cycle latency
//   clr_start/clr_mask/clr_value start a clear of the masked layers
//   clr_busy/clr_done            clear engine status / completion pulse
module uxn_vram_layered #(
  parameter int unsigned PIXEL_W = 2,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned LAYERS  = 2,
  localparam int unsigned LAYER_W = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [LAYER_W-1:0] wr_layer,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_value,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_value,
  output logic               rd_valid,
  input  logic               clr_start,
  input  logic [LAYERS-1:0]  clr_mask,
  input  logic [PIXEL_W-1:0] clr_value,
  output logic               clr_busy,
  output logic               clr_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LAYERS-1:0]    mask_q, mask_d;
  logic [PIXEL_W-1:0]   fill_q, fill_d;
  logic                 done_q, done_d;

  logic [LAYERS-1:0]    clr_we_c;
  logic [ADDR_W-1:0]    clr_addr_c;

  logic [LAYERS*PIXEL_W-1:0] pix_all_c;
  logic [PIXEL_W-1:0]        comp_c;
  logic                      rd_en_q;
  logic                      rd_valid_q;
  logic [PIXEL_W-1:0]        rd_value_q;

  // Clear FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      fill_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
    end
  end

  // Clear FSM next state; clr_start is ignored unless idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          mask_d  = clr_mask;
          fill_d  = clr_value;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear FSM outputs: per-layer fill strobes at the current counter
  always_comb begin
    clr_we_c   = '0;
    clr_addr_c = cnt_q[ADDR_W-1:0];
    if (state_q == ST_CLEAR) clr_we_c = mask_q;
  end

  // One RAM per layer; a masked layer under clear ignores host writes
  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    logic                host_hit_c;
    logic                we_c;
    logic [ADDR_W-1:0]   waddr_c;
    logic [PIXEL_W-1:0]  wdata_c;
    logic [PIXEL_W-1:0]  mem_q [DEPTH];
    logic [PIXEL_W-1:0]  pix_q;

    assign host_hit_c = wr_en && (wr_layer == LAYER_W'(l));

    always_comb begin
      we_c    = host_hit_c;
      waddr_c = wr_addr;
      wdata_c = wr_value;
      if (clr_we_c[l]) begin
        we_c    = 1'b1;
        waddr_c = clr_addr_c;
        wdata_c = fill_q;
      end
    end

    // Read stage 1; non-blocking update gives read-before-write
    always_ff @(posedge clk) begin
      if (we_c)  mem_q[waddr_c] <= wdata_c;
      if (rd_en) pix_q <= mem_q[rd_addr];
    end

    assign pix_all_c[l*PIXEL_W +: PIXEL_W] = pix_q;
  end

  // Highest-index non-zero layer wins; layer 0 otherwise
  always_comb begin
    comp_c = pix_all_c[PIXEL_W-1:0];
    for (int i = 1; i < int'(LAYERS); i++) begin
      if (pix_all_c[i*PIXEL_W +: PIXEL_W] != '0) comp_c = pix_all_c[i*PIXEL_W +: PIXEL_W];
    end
  end

  // Read stage 2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_value_q <= '0;
    end else begin
      rd_en_q    <= rd_en;
      rd_valid_q <= rd_en_q;
      if (rd_en_q) rd_value_q <= comp_c;
    end
  end

  assign rd_value = rd_value_q;
  assign rd_valid = rd_valid_q;
  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = done_q;

endmodule

// File: tb/tb_uxn_vram_layered.sv
// Self-checking bench for uxn_vram_layered (ADDR_W=4, LAYERS=2, PIXEL_W=2)
// plus a LAYERS=1 instance for the out-of-range layer write.
module tb_uxn_vram_layered;

  localparam int LAYERS = 2;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [0:0] wr_layer;
  logic [3:0] wr_addr;
  logic [1:0] wr_value;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [1:0] rd_value;
  logic       rd_valid;
  logic       clr_start;
  logic [1:0] clr_mask;
  logic [1:0] clr_value;
  logic       clr_busy;
  logic       clr_done;

  logic       d1_wr_en;
  logic [0:0] d1_wr_layer;
  logic [3:0] d1_wr_addr;
  logic [1:0] d1_wr_value;
  logic       d1_rd_en;
  logic [3:0] d1_rd_addr;
  logic [1:0] d1_rd_value;
  logic       d1_rd_valid;
  logic       d1_clr_start;
  logic [0:0] d1_clr_mask;
  logic [1:0] d1_clr_value;
  logic       d1_clr_busy;
  logic       d1_clr_done;

  uxn_vram_layered #(.PIXEL_W(2), .ADDR_W(4), .LAYERS(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_layer(wr_layer), .wr_addr(wr_addr), .wr_value(wr_value),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_value(rd_value), .rd_valid(rd_valid),
    .clr_start(clr_start), .clr_mask(clr_mask), .clr_value(clr_value),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  uxn_vram_layered #(.PIXEL_W(2), .ADDR_W(4), .LAYERS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(d1_wr_en), .wr_layer(d1_wr_layer), .wr_addr(d1_wr_addr), .wr_value(d1_wr_value),
    .rd_en(d1_rd_en), .rd_addr(d1_rd_addr), .rd_value(d1_rd_value), .rd_valid(d1_rd_valid),
    .clr_start(d1_clr_start), .clr_mask(d1_clr_mask), .clr_value(d1_clr_value),
    .clr_busy(d1_clr_busy), .clr_done(d1_clr_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain pixel arrays plus the clear engine's progress
  logic [1:0] m_ram   [LAYERS][DEPTH];
  bit         m_known [LAYERS][DEPTH];
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_cnt  = 0;
  logic [1:0] m_mask = '0;
  logic [1:0] m_fill = '0;

  typedef struct {
    logic [1:0] val;
    bit         known;
    int         issued;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Search layers top-down for the first non-zero pixel
  task automatic model_read(input int a, output logic [1:0] v, output bit k);
    v = m_ram[0][a];
    k = m_known[0][a];
    for (int l = LAYERS - 1; l > 0; l--) begin
      if (!m_known[l][a]) begin
        k = 1'b0;
        break;
      end
      if (m_ram[l][a] != 2'd0) begin
        v = m_ram[l][a];
        k = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_layer = '0; wr_addr = '0; wr_value = '0;
    rd_en = 0; rd_addr = '0;
    clr_start = 0; clr_mask = '0; clr_value = '0;
    d1_wr_en = 0; d1_wr_layer = '0; d1_wr_addr = '0; d1_wr_value = '0;
    d1_rd_en = 0; d1_rd_addr = '0;
    d1_clr_start = 0; d1_clr_mask = '0; d1_clr_value = '0;
  endtask

  // Apply the current inputs to the model for the coming edge, then clock
  task automatic step();
    exp_t e;
    bit   was_busy;
    was_busy = m_busy;
    if (rd_en) begin
      model_read(int'(rd_addr), e.val, e.known);
      e.issued = cyc;
      sb.push_back(e);
    end
    if (wr_en && int'(wr_layer) < LAYERS && !(was_busy && m_mask[wr_layer])) begin
      m_ram[wr_layer][wr_addr]   = wr_value;
      m_known[wr_layer][wr_addr] = 1'b1;
    end
    m_done = 1'b0;
    if (was_busy) begin
      for (int l = 0; l < LAYERS; l++) begin
        if (m_mask[l]) begin
          m_ram[l][m_cnt]   = m_fill;
          m_known[l][m_cnt] = 1'b1;
        end
      end
      if (m_cnt == DEPTH - 1) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_cnt++;
      end
    end else if (clr_start) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      m_mask = clr_mask;
      m_fill = clr_value;
    end
    @(posedge clk);
    #1;
    chk("clr_busy", int'(clr_busy), int'(m_busy));
    chk("clr_done", int'(clr_done), int'(m_done));
  endtask

  task automatic wr(input int l, input int a, input int v);
    idle();
    wr_en = 1; wr_layer = 1'(l); wr_addr = 4'(a); wr_value = 2'(v);
    step();
    idle();
  endtask

  task automatic rd(input int a);
    idle();
    rd_en = 1; rd_addr = 4'(a);
    step();
    idle();
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  task automatic start_clear(input int m, input int v);
    idle();
    clr_start = 1; clr_mask = 2'(m); clr_value = 2'(v);
    step();
    idle();
  endtask

  task automatic finish_clear();
    int n;
    n = clr_busy ? 1 : 0;
    while (clr_busy && n < 40) begin
      step();
      if (clr_busy) n++;
    end
    chk("busy_len", n, DEPTH);
    chk("done_pulse", int'(clr_done), 1);
    step();
  endtask

  // Called at posedge+1: asserts reset mid-cycle and checks outputs at once
  task automatic do_reset();
    idle();
    #2 reset_n = 0;
    #1;
    chk("rst_rd_value", int'(rd_value), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_clr_busy", int'(clr_busy), 0);
    chk("rst_clr_done", int'(clr_done), 0);
    m_busy = 1'b0;
    m_done = 1'b0;
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rd_valid pops one expectation; overdue entries are misses
  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          chk("rd_unexpected_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("rd_latency", cyc - mon_e.issued, 2);
          if (mon_e.known) chk("rd_value", int'(rd_value), int'(mon_e.val));
        end
      end else if (sb.size() != 0 && cyc - sb[0].issued >= 2) begin
        mon_e = sb.pop_front();
        chk("rd_missing_valid", 0, 1);
      end
    end
  end

  initial begin
    int n;
    int i;
    logic [1:0] v;
    bit k;
    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1;
    @(posedge clk);
    #1;

    // Reads before any writes, then async reset while rd_valid is high
    rd(0); rd(1); rd(2);
    chk("pre_reset_valid", int'(rd_valid), 1);
    do_reset();

    // Known starting contents
    start_clear(3, 0);
    finish_clear();

    // Basic composite, back-to-back reads
    wr(0, 5, 1); wr(1, 5, 0); wr(0, 6, 2); wr(1, 6, 3);
    rd(5); rd(6); rd(7);
    drain();

    // Same-cycle write and read returns old data
    idle();
    wr_en = 1; wr_layer = 1'(1); wr_addr = 4'd9; wr_value = 2'd2;
    rd_en = 1; rd_addr = 4'd9;
    step();
    rd(9);
    drain();
    model_read(9, v, k);
    chk("rd_hold", int'(rd_value), int'(v));

    // Clear layer 1 to 1, read all, then zero layer 1 to expose layer 0
    start_clear(2, 1);
    finish_clear();
    for (int a = 0; a < DEPTH; a++) rd(a);
    for (int a = 0; a < DEPTH; a++) wr(1, a, 0);
    for (int a = 0; a < DEPTH; a++) rd(a);
    drain();

    // Clear layer 0 with host writes and a second start in flight
    start_clear(1, 3);
    n = clr_busy ? 1 : 0;
    i = 0;
    while (clr_busy && n < 40) begin
      idle();
      case (i)
        2:  begin wr_en = 1; wr_layer = 1'(1); wr_addr = 4'd3;  wr_value = 2'd2; end
        5:  begin clr_start = 1; clr_mask = 2'b10; clr_value = 2'd2; end
        10: begin wr_en = 1; wr_layer = 1'(0); wr_addr = 4'd3;  wr_value = 2'd1; end
        13: begin wr_en = 1; wr_layer = 1'(0); wr_addr = 4'd12; wr_value = 2'd1; end
        default: ;
      endcase
      step();
      i++;
      if (clr_busy) n++;
    end
    chk("busy_len_restart", n, DEPTH);
    step();
    for (int a = 0; a < DEPTH; a++) rd(a);
    drain();

    // Reset after eight clear cycles
    for (int a = 0; a < DEPTH; a++) begin
      wr(0, a, int'($urandom_range(0, 3)));
      wr(1, a, int'($urandom_range(0, 3)));
    end
    start_clear(3, 2);
    repeat (8) step();
    do_reset();
    idle();
    repeat (2) step();
    for (int a = 0; a < DEPTH; a++) rd(a);
    drain();

    // Empty mask still runs the full sweep
    start_clear(0, 3);
    finish_clear();
    for (int a = 0; a < DEPTH; a++) rd(a);
    drain();

    // Single-layer build drops writes to layer 1
    idle();
    d1_wr_en = 1; d1_wr_layer = 1'(0); d1_wr_addr = 4'd2; d1_wr_value = 2'd1;
    step();
    idle();
    d1_wr_en = 1; d1_wr_layer = 1'(1); d1_wr_addr = 4'd2; d1_wr_value = 2'd3;
    step();
    idle();
    d1_rd_en = 1; d1_rd_addr = 4'd2;
    step();
    idle();
    step();
    chk("d1_rd_valid", int'(d1_rd_valid), 1);
    chk("d1_rd_value", int'(d1_rd_value), 1);
    chk("d1_clr_busy", int'(d1_clr_busy), 0);
    chk("d1_clr_done", int'(d1_clr_done), 0);

    // Randomized traffic including clears
    for (int t = 0; t < 500; t++) begin
      idle();
      wr_en    = 1'($urandom_range(0, 1));
      wr_layer = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom_range(0, 15));
      wr_value = 2'($urandom_range(0, 3));
      rd_en    = 1'($urandom_range(0, 1));
      rd_addr  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin
        clr_start = 1;
        clr_mask  = 2'($urandom_range(0, 3));
        clr_value = 2'($urandom_range(0, 3));
      end
      step();
    end
    idle();
    n = 0;
    while (m_busy && n < 40) begin
      step();
      n++;
    end
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
